// File: rtl/alu_ctrl_defs.sv
// Shared encodings for the multi-cycle control unit: ALU operation codes,
// operand-select codes, major opcodes and the controller state enum.
package alu_ctrl_defs;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_CONST4 = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_BRANCH,
        ST_ILLEGAL
    } state_t;

    // States that hold a memory strobe and are guarded by the wait counter.
    function automatic logic is_mem_wait_state(state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation decode from controller state and instruction
// fields; also flags funct3 values that have no meaning in the current state.
module alu_op_decoder
    import alu_ctrl_defs::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op,
    output logic       illegal
);

    logic is_r;

    assign is_r = (opcode == OPC_R);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (state)
            ST_IDLE: alu_op = 4'b0000;
            ST_EXEC_R, ST_EXEC_I: begin
                case (funct3)
                    3'b000:  alu_op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    default: illegal = 1'b1;
                endcase
            end
            ST_BRANCH: begin
                alu_op  = ALU_SUB;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback,
// drives ALU operand selects and resolves branches from the ALU flags.
module multicycle_control_unit
    import alu_ctrl_defs::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       equal,
    input  logic       not_equal,
    input  logic       lesser_than,
    input  logic       greater_or_equal,
    input  logic       unsigned_lesser,
    input  logic       unsigned_greater_equal,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_read,
    output logic       mem_write,
    output logic       branch_taken,
    output logic       illegal_instr,
    output logic       mem_fault
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q;
    logic       timeout;
    logic       flag_sel;
    logic       dec_illegal;

    alu_op_decoder u_alu_op_decoder (
        .state    (state_q),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_op   (alu_op),
        .illegal  (dec_illegal)
    );

    // A ready arriving on the last permitted cycle completes normally.
    assign timeout = is_mem_wait_state(state_q) && !mem_ready && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        flag_sel = 1'b0;
        case (funct3)
            3'b000:  flag_sel = equal;
            3'b001:  flag_sel = not_equal;
            3'b100:  flag_sel = lesser_than;
            3'b101:  flag_sel = greater_or_equal;
            3'b110:  flag_sel = unsigned_lesser;
            3'b111:  flag_sel = unsigned_greater_equal;
            default: flag_sel = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (timeout || (state_d != state_q))
                wait_cnt_q <= '0;
            else if (is_mem_wait_state(state_q) && !mem_ready)
                wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        pc_src        = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        branch_taken  = 1'b0;
        illegal_instr = 1'b0;
        mem_fault     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                alu_src_b = SRC_B_CONST4;
                if (timeout) begin
                    mem_fault = 1'b1;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OPC_R:                 state_d = ST_EXEC_R;
                    OPC_I:                 state_d = ST_EXEC_I;
                    OPC_LOAD, OPC_STORE:   state_d = ST_MEM_ADDR;
                    OPC_BRANCH:            state_d = ST_BRANCH;
                    default:               state_d = ST_ILLEGAL;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = (state_q == ST_EXEC_I) ? SRC_B_IMM : SRC_B_RS2;
                state_d   = dec_illegal ? ST_ILLEGAL : ST_WB_ALU;
            end
            ST_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (timeout) begin
                    mem_fault = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    mem_read  = (state_q == ST_MEM_RD);
                    mem_write = (state_q == ST_MEM_WR);
                    if (mem_ready)
                        state_d = (state_q == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
                end
            end
            ST_WB_ALU: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                pc_src    = 1'b1;
                if (dec_illegal) begin
                    illegal_instr = 1'b1;
                end else begin
                    branch_taken = flag_sel;
                    pc_write     = flag_sel;
                end
                state_d = ST_FETCH;
            end
            ST_ILLEGAL: begin
                illegal_instr = 1'b1;
                state_d       = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed and random instructions, expected per-cycle
// outputs derived from an instruction-level model of the control sequence.
module tb_multicycle_control_unit;

    localparam int MAX = 4;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch_taken;
        logic       illegal_instr;
        logic       mem_fault;
    } obs_t;

    logic       clk, rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       equal, not_equal, lesser_than, greater_or_equal;
    logic       unsigned_lesser, unsigned_greater_equal, mem_ready;
    logic [3:0] alu_op;
    logic [1:0] alu_src_a, alu_src_b;
    logic       pc_src, pc_write, ir_write, reg_write, mem_to_reg;
    logic       mem_read, mem_write, branch_taken, illegal_instr, mem_fault;
    obs_t       obs_now;

    int total = 0;
    int bad   = 0;

    multicycle_control_unit #(.MEM_WAIT_MAX(MAX)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .opcode                 (opcode),
        .funct3                 (funct3),
        .funct7_5               (funct7_5),
        .equal                  (equal),
        .not_equal              (not_equal),
        .lesser_than            (lesser_than),
        .greater_or_equal       (greater_or_equal),
        .unsigned_lesser        (unsigned_lesser),
        .unsigned_greater_equal (unsigned_greater_equal),
        .mem_ready              (mem_ready),
        .alu_op                 (alu_op),
        .alu_src_a              (alu_src_a),
        .alu_src_b              (alu_src_b),
        .pc_src                 (pc_src),
        .pc_write               (pc_write),
        .ir_write               (ir_write),
        .reg_write              (reg_write),
        .mem_to_reg             (mem_to_reg),
        .mem_read               (mem_read),
        .mem_write              (mem_write),
        .branch_taken           (branch_taken),
        .illegal_instr          (illegal_instr),
        .mem_fault              (mem_fault)
    );

    assign obs_now = {alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, reg_write,
                      mem_to_reg, mem_read, mem_write, branch_taken, illegal_instr, mem_fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic obs_t base_exp();
        obs_t e = '0;
        e.alu_op = OP_ADD;
        return e;
    endfunction

    // Operand selects and pc_src are only meaningful where explicitly driven.
    function automatic obs_t base_care();
        obs_t c = '1;
        c.src_a  = '0;
        c.src_b  = '0;
        c.pc_src = 1'b0;
        return c;
    endfunction

    // One clock of the instruction trace: drive mem_ready, compare, advance.
    task automatic slot(input string tag, input logic rdy, input obs_t e, input obs_t c);
        mem_ready = rdy;
        #1;
        check(tag, 32'(obs_now & c), 32'(e & c));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_release();
        check("reset_outputs", 32'(obs_now), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        slot("idle", 1'b0, '0, '1);
    endtask

    task automatic do_fetch(input int w, output bit ok);
        obs_t e, c;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            e = base_exp(); c = base_care();
            e.src_a = 2'b00; e.src_b = 2'b01; c.src_a = '1; c.src_b = '1;
            if (k == w) begin
                e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; c.pc_src = 1'b1;
                slot("fetch_done", 1'b1, e, c);
                ok = 1'b1;
                return;
            end else if (k == MAX - 1) begin
                e.mem_fault = 1;
                slot("fetch_fault", 1'b0, e, c);
                return;
            end
            e.mem_read = 1;
            slot("fetch_wait", 1'b0, e, c);
        end
    endtask

    // rst_at >= 0 asserts rst_n mid-cycle on that wait cycle of the memory phase.
    task automatic do_mem(input bit st, input int w, input int rst_at, output bit ok);
        obs_t e, c;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            e = base_exp(); c = base_care();
            if (k == rst_at) begin
                mem_ready = 1'b0;
                #1;
                check("mem_strobe_pre_rst", 32'(st ? mem_write : mem_read), 32'(1));
                rst_n = 1'b0;
                #1;
                check("async_rst_drop", 32'(obs_now), 32'(0));
                reset_and_release();
                return;
            end
            if (k == w) begin
                e.mem_read = !st; e.mem_write = st;
                slot("mem_done", 1'b1, e, c);
                ok = 1'b1;
                return;
            end else if (k == MAX - 1) begin
                e.mem_fault = 1;
                slot("mem_fault", 1'b0, e, c);
                return;
            end
            e.mem_read = !st; e.mem_write = st;
            slot("mem_wait", 1'b0, e, c);
        end
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic [5:0] flg,
                             input int fw, input int mw, input int rst_at);
        obs_t e, c;
        bit ok, legal, taken;
        logic [2:0] f3;
        opcode   = ir[6:0];
        funct3   = ir[14:12];
        funct7_5 = ir[30];
        f3       = ir[14:12];
        {equal, not_equal, lesser_than, greater_or_equal,
         unsigned_lesser, unsigned_greater_equal} = flg;

        do_fetch(fw, ok);
        if (!ok) return;

        e = base_exp(); c = base_care();
        e.src_a = 2'b01; e.src_b = 2'b10; c.src_a = '1; c.src_b = '1;
        slot("decode", 1'b0, e, c);

        case (ir[6:0])
            7'b0110011, 7'b0010011: begin
                legal = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110);
                e = base_exp(); c = base_care();
                e.src_a = 2'b10; e.src_b = (ir[6:0] == 7'b0110011) ? 2'b00 : 2'b10;
                c.src_a = '1; c.src_b = '1;
                if (f3 == 3'b111)      e.alu_op = OP_AND;
                else if (f3 == 3'b110) e.alu_op = OP_OR;
                else if (ir[6:0] == 7'b0110011 && ir[30]) e.alu_op = OP_SUB;
                else                   e.alu_op = OP_ADD;
                if (!legal) c.alu_op = '0;
                slot("exec", 1'b0, e, c);
                e = base_exp(); c = base_care();
                if (legal) begin
                    e.reg_write = 1;
                    slot("wb_alu", 1'b0, e, c);
                end else begin
                    e.illegal_instr = 1;
                    slot("illegal_f3", 1'b0, e, c);
                end
            end
            7'b0000011, 7'b0100011: begin
                e = base_exp(); c = base_care();
                e.src_a = 2'b10; e.src_b = 2'b10; c.src_a = '1; c.src_b = '1;
                slot("mem_addr", 1'b0, e, c);
                do_mem(ir[6:0] == 7'b0100011, mw, rst_at, ok);
                if (ok && ir[6:0] == 7'b0000011) begin
                    e = base_exp(); c = base_care();
                    e.reg_write = 1; e.mem_to_reg = 1;
                    slot("wb_mem", 1'b0, e, c);
                end
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  taken = flg[5];
                    3'b001:  taken = flg[4];
                    3'b100:  taken = flg[3];
                    3'b101:  taken = flg[2];
                    3'b110:  taken = flg[1];
                    3'b111:  taken = flg[0];
                    default: taken = 1'b0;
                endcase
                e = base_exp(); c = base_care();
                e.alu_op = OP_SUB; e.src_a = 2'b10; e.src_b = 2'b00;
                c.src_a = '1; c.src_b = '1;
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    e.illegal_instr = 1;
                end else begin
                    e.branch_taken = taken; e.pc_write = taken;
                    e.pc_src = 1'b1; c.pc_src = 1'b1;
                end
                slot("branch", 1'b0, e, c);
            end
            default: begin
                e = base_exp(); c = base_care();
                e.illegal_instr = 1;
                slot("illegal_opc", 1'b0, e, c);
            end
        endcase
    endtask

    initial begin
        logic [31:0] ir;
        logic [6:0]  opc_tab [6];
        rst_n = 1'b0; mem_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        {equal, not_equal, lesser_than, greater_or_equal,
         unsigned_lesser, unsigned_greater_equal} = '0;
        opc_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1111111};
        repeat (2) @(posedge clk);
        #1;
        reset_and_release();

        run_instr(32'h002081B3, 6'b000000, 0, 0, -1);  // add
        run_instr(32'h402081B3, 6'b000000, 1, 0, -1);  // sub
        run_instr(32'h0020F1B3, 6'b000000, 0, 0, -1);  // and
        run_instr(32'h0020E1B3, 6'b000000, 2, 0, -1);  // or
        run_instr(32'h002091B3, 6'b000000, 0, 0, -1);  // R with bad funct3
        run_instr(32'h00508093, 6'b000000, 0, 0, -1);  // addi
        run_instr(32'h4050F093, 6'b000000, 0, 0, -1);  // andi, funct7_5 ignored
        run_instr(32'h00208063, 6'b100000, 0, 0, -1);  // beq taken
        run_instr(32'h00208063, 6'b011111, 0, 0, -1);  // beq not taken
        run_instr(32'h0020E063, 6'b000010, 0, 0, -1);  // bltu taken
        run_instr(32'h0020E063, 6'b111101, 0, 0, -1);  // bltu not taken
        run_instr(32'h0020F063, 6'b000001, 0, 0, -1);  // bgeu taken
        run_instr(32'h0020F063, 6'b111110, 0, 0, -1);  // bgeu not taken
        run_instr(32'h0020A063, 6'b111111, 0, 0, -1);  // branch funct3 010
        run_instr(32'h0000A183, 6'b000000, 0, 3, -1);  // lw, 3 wait cycles
        run_instr(32'h0020A023, 6'b000000, 0, 1, -1);  // sw
        run_instr(32'h002081B3, 6'b000000, 10, 0, -1); // fetch timeout
        run_instr(32'h002081B3, 6'b000000, MAX - 1, 0, -1); // ready on last cycle
        run_instr(32'h0000A183, 6'b000000, 0, 10, -1); // load timeout
        run_instr(32'h0020A023, 6'b000000, 0, 10, -1); // store timeout
        run_instr(32'h0000007F, 6'b000000, 0, 0, -1);  // undecodable opcode
        run_instr(32'h0020A023, 6'b000000, 0, 10, 1);  // reset during MEM_WR
        run_instr(32'h002081B3, 6'b000000, 0, 0, -1);  // resumes after reset

        for (int n = 0; n < 300; n++) begin
            int fw, mw;
            ir = $urandom;
            ir[6:0] = opc_tab[$urandom_range(0, 5)];
            fw = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 2) : $urandom_range(3, 6);
            mw = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 2) : $urandom_range(3, 6);
            run_instr(ir, 6'($urandom), fw, mw, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
